// File: rtl/dcache_ctrl_param.sv
// Single-line data-cache controller: write-through stores, optional write-allocate,
// critical-word-first wrapping refills with the load answered on the first beat.
module dcache_ctrl_param #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned LINE_WORDS     = 4,
  parameter bit          WRITE_ALLOCATE = 1'b1,
  localparam int unsigned BE_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lsu_req,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_we,
  input  logic [BE_WIDTH-1:0]   lsu_be,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  output logic                  lsu_gnt,
  output logic                  lsu_rvalid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic                  cache_we,
  output logic [BE_WIDTH-1:0]   cache_be,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_hit,
  output logic                  cache_fill_done,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [BE_WIDTH-1:0]   mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned OFF = $clog2(BE_WIDTH);
  localparam int unsigned IB  = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    StIdle, StLookup, StWtReq, StWtWait, StRefillReq, StRefillWait, StAllocWr
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [IB-1:0]         idx_q, idx_d;
  logic [IB-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] refill_addr;

  // Line base from the captured address, word slot from the wrapping index.
  assign refill_addr = {addr_q[ADDR_WIDTH-1:OFF+IB], {(OFF+IB){1'b0}}}
                     | (ADDR_WIDTH'(idx_q) << OFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    we_d            = we_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    lsu_gnt         = 1'b0;
    lsu_rvalid      = 1'b0;
    lsu_rdata       = '0;
    cache_addr      = '0;
    cache_we        = 1'b0;
    cache_be        = '0;
    cache_wdata     = '0;
    cache_fill_done = 1'b0;
    mem_req         = 1'b0;
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_be          = '0;
    mem_wdata       = '0;
    busy            = 1'b0;

    // Outputs are held quiet while reset is asserted so an in-flight beat cannot leak out.
    if (!reset) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (lsu_req) begin
            lsu_gnt = 1'b1;
            addr_d  = lsu_addr;
            we_d    = lsu_we;
            be_d    = lsu_be;
            wdata_d = lsu_wdata;
            state_d = StLookup;
          end
        end
        StLookup: begin
          cache_addr = addr_q;
          if (cache_hit && !we_q) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = cache_rdata;
            if (lsu_req) begin
              lsu_gnt = 1'b1;
              addr_d  = lsu_addr;
              we_d    = lsu_we;
              be_d    = lsu_be;
              wdata_d = lsu_wdata;
            end else begin
              state_d = StIdle;
            end
          end else if (cache_hit) begin
            cache_we    = 1'b1;
            cache_be    = be_q;
            cache_wdata = wdata_q;
            state_d     = StWtReq;
          end else if (!we_q || WRITE_ALLOCATE) begin
            idx_d   = addr_q[OFF+IB-1:OFF];
            cnt_d   = '0;
            state_d = StRefillReq;
          end else begin
            state_d = StWtReq;
          end
        end
        StWtReq: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = addr_q;
          mem_be    = be_q;
          mem_wdata = wdata_q;
          if (mem_gnt) state_d = StWtWait;
        end
        StWtWait: begin
          if (mem_rvalid) begin
            lsu_rvalid = 1'b1;
            state_d    = StIdle;
          end
        end
        StRefillReq: begin
          mem_req  = 1'b1;
          mem_be   = '1;
          mem_addr = refill_addr;
          if (mem_gnt) state_d = StRefillWait;
        end
        StRefillWait: begin
          if (mem_rvalid) begin
            cache_we    = 1'b1;
            cache_be    = '1;
            cache_addr  = refill_addr;
            cache_wdata = mem_rdata;
            if (cnt_q == '0 && !we_q) begin
              lsu_rvalid = 1'b1;
              lsu_rdata  = mem_rdata;
            end
            cnt_d = cnt_q + IB'(1);
            idx_d = idx_q + IB'(1);
            if (cnt_q == IB'(LINE_WORDS - 1)) begin
              cache_fill_done = 1'b1;
              state_d         = we_q ? StAllocWr : StIdle;
            end else begin
              state_d = StRefillReq;
            end
          end
        end
        StAllocWr: begin
          cache_we    = 1'b1;
          cache_be    = be_q;
          cache_addr  = addr_q;
          cache_wdata = wdata_q;
          state_d     = StWtReq;
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule
